// File: rtl/alu_share_ctrl_pkg.sv
// alu_share_ctrl_pkg: shared Alu widths and scheduler state encoding
package alu_share_ctrl_pkg;
    localparam int WIDTH = 32;
    localparam int OPW = 3;
    localparam int CNTW = 16;
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;
endpackage

// File: rtl/alu_share_ctrl_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant, the requester not granted last wins a tie
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);
    always_comb gnt_o = (req_i == 2'b11) ? (last_i ? 2'b01 : 2'b10) : req_i;
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin scheduler time-sharing one combinational Alu between two requesters
module alu_share_ctrl #(
    parameter int WIDTH = alu_share_ctrl_pkg::WIDTH,
    parameter int OPW   = alu_share_ctrl_pkg::OPW,
    parameter int CNTW  = alu_share_ctrl_pkg::CNTW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [OPW-1:0]   op0,
    input  logic [OPW-1:0]   op1,
    input  logic             unsig0,
    input  logic             unsig1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    output logic             alu_unsig,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_compout,
    input  logic             alu_overflow,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             result_comp,
    output logic             result_ovf,
    output logic             result_owner,
    output logic             busy,
    output logic [CNTW-1:0]  ops_count
);
    import alu_share_ctrl_pkg::*;
    state_e state_q;
    logic last_q;
    logic owner_q;
    logic [1:0] gnt;
    logic win;
    rr_arbiter2 u_arb (
        .req_i ({req1, req0}),
        .last_i(last_q),
        .gnt_o (gnt)
    );
    assign win = gnt[1];
    // done and busy are registered so they line up exactly with the DONE/ISSUE cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            alu_unsig    <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            result       <= '0;
            result_comp  <= 1'b0;
            result_ovf   <= 1'b0;
            result_owner <= 1'b0;
            busy         <= 1'b0;
            ops_count    <= '0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state_q)
                IDLE: if (|gnt) begin
                    alu_a     <= win ? a1 : a0;
                    alu_b     <= win ? b1 : b0;
                    alu_op    <= win ? op1 : op0;
                    alu_unsig <= win ? unsig1 : unsig0;
                    owner_q   <= win;
                    last_q    <= win;
                    busy      <= 1'b1;
                    state_q   <= ISSUE;
                end
                ISSUE: begin
                    result       <= alu_out;
                    result_comp  <= alu_compout;
                    result_ovf   <= alu_overflow;
                    result_owner <= owner_q;
                    ops_count    <= ops_count + CNTW'(1);
                    done0        <= !owner_q;
                    done1        <= owner_q;
                    state_q      <= DONE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: randomized two-client traffic against a transaction-level scheduler model
module tb_alu_share_ctrl;
    localparam int W = 32;
    localparam int OPW = 3;
    localparam int CW = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req0, req1, unsig0, unsig1;
    logic [W-1:0] a0, b0, a1, b1, alu_a, alu_b, alu_out, result;
    logic [OPW-1:0] op0, op1, alu_op;
    logic alu_unsig, alu_compout, alu_overflow;
    logic done0, done1, result_comp, result_ovf, result_owner, busy;
    logic [CW-1:0] ops_count;
    int checks = 0;
    int errors = 0;
    logic cr[2];
    logic [W-1:0] ca[2], cb[2];
    logic [OPW-1:0] cop[2];
    logic cu[2];
    int gap[2];
    bit got[2], en[2];
    bit rnd_ops, rst_next;
    int gmax;
    int cyc = 0;
    bit mv = 0;
    int idle_at, pend_at, m_cnt;
    bit m_last, pend, pend_own, m_comp, m_ovf, m_own;
    logic [W-1:0] ea, eb, m_res;
    logic [OPW-1:0] eop;
    logic eu;
    logic [W+1:0] pend_res;
    bit owners[$];

    always #5 clk = ~clk;

    assign req0 = cr[0];
    assign req1 = cr[1];
    assign a0 = ca[0];
    assign b0 = cb[0];
    assign a1 = ca[1];
    assign b1 = cb[1];
    assign op0 = cop[0];
    assign op1 = cop[1];
    assign unsig0 = cu[0];
    assign unsig1 = cu[1];

    alu_share_ctrl #(.WIDTH(W), .OPW(OPW), .CNTW(CW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .op0(op0), .op1(op1), .unsig0(unsig0), .unsig1(unsig1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_unsig(alu_unsig),
        .alu_out(alu_out), .alu_compout(alu_compout), .alu_overflow(alu_overflow),
        .done0(done0), .done1(done1),
        .result(result), .result_comp(result_comp), .result_ovf(result_ovf),
        .result_owner(result_owner), .busy(busy), .ops_count(ops_count)
    );

    function automatic logic [W+1:0] alu_fn(logic [W-1:0] a, logic [W-1:0] b, logic [OPW-1:0] op, logic u);
        logic [W:0] s;
        logic [W-1:0] r;
        logic c, v;
        s = '0;
        v = 1'b0;
        c = u ? (a < b) : ($signed(a) < $signed(b));
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; v = u ? s[W] : (a[W-1] == b[W-1] && r[W-1] != a[W-1]); end
            3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[W-1:0]; v = u ? s[W] : (a[W-1] != b[W-1] && r[W-1] != a[W-1]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = {{(W-1){1'b0}}, c};
            3'd6: r = a << b[4:0];
            default: r = u ? (a >> b[4:0]) : W'($signed(a) >>> b[4:0]);
        endcase
        return {v, c, r};
    endfunction

    assign {alu_overflow, alu_compout, alu_out} = alu_fn(alu_a, alu_b, alu_op, alu_unsig);

    task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got_v, exp_v, cyc);
        end
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(5, 0))
            0: v = '0;
            1: v = 32'h7FFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'hFFFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic rand_ops(input int i);
        ca[i] = pick();
        cb[i] = pick();
        cop[i] = OPW'($urandom_range(7, 0));
        cu[i] = 1'($urandom_range(1, 0));
    endtask

    task automatic observe();
        bit d0, d1, w;
        d0 = 0;
        d1 = 0;
        if (mv) begin
            if (pend && pend_at == cyc) begin
                {m_ovf, m_comp, m_res} = pend_res;
                m_own = pend_own;
                m_cnt = (m_cnt + 1) % (1 << CW);
                d0 = !pend_own;
                d1 = pend_own;
                pend = 0;
                owners.push_back(pend_own);
            end
            chk("done0", done0, d0);
            chk("done1", done1, d1);
            chk("busy", busy, cyc < idle_at);
            chk("result", result, m_res);
            chk("result_comp", result_comp, m_comp);
            chk("result_ovf", result_ovf, m_ovf);
            chk("result_owner", result_owner, m_own);
            chk("ops_count", ops_count, 64'(m_cnt));
            chk("alu_a", alu_a, ea);
            chk("alu_b", alu_b, eb);
            chk("alu_op", alu_op, eop);
            chk("alu_unsig", alu_unsig, eu);
        end
        if (done0 === 1'b1) got[0] = 1;
        if (done1 === 1'b1) got[1] = 1;
        if (reset) begin
            mv = 1;
            idle_at = cyc + 1;
            m_last = 1;
            ea = '0; eb = '0; eop = '0; eu = 1'b0;
            pend = 0;
            m_res = '0; m_comp = 0; m_ovf = 0; m_own = 0; m_cnt = 0;
        end else if (mv && cyc >= idle_at && (cr[0] || cr[1])) begin
            w = (cr[0] && cr[1]) ? !m_last : cr[1];
            ea = ca[w]; eb = cb[w]; eop = cop[w]; eu = cu[w];
            pend = 1;
            pend_at = cyc + 2;
            pend_own = w;
            pend_res = alu_fn(ca[w], cb[w], cop[w], cu[w]);
            idle_at = cyc + 3;
            m_last = w;
        end
        cyc++;
    endtask

    task automatic cycle_();
        @(posedge clk);
        #1;
        reset = rst_next;
        for (int i = 0; i < 2; i++) begin
            if (got[i]) begin
                cr[i] = 0;
                got[i] = 0;
                gap[i] = int'($urandom_range(gmax, 0));
            end else if (!cr[i]) begin
                if (en[i] && gap[i] == 0) begin
                    cr[i] = 1;
                    if (rnd_ops) rand_ops(i);
                end else if (gap[i] > 0) gap[i]--;
            end else if (rnd_ops && !(pend && pend_own == i) && $urandom_range(3, 0) == 0) rand_ops(i);
        end
        @(negedge clk);
        observe();
    endtask

    task automatic wait_done(input int i, output int at);
        int k;
        k = 0;
        while (!got[i] && k < 20) begin
            cycle_();
            k++;
        end
        chk(i ? "wait_done1" : "wait_done0", got[i], 1);
        at = cyc - 1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((cr[0] || cr[1] || busy) && k < 30) begin
            cycle_();
            k++;
        end
        cycle_();
    endtask

    task automatic do_reset();
        rst_next = 1;
        cycle_();
        rst_next = 0;
    endtask

    task automatic one_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [OPW-1:0] op, input logic u, output int g, output int at);
        ca[i] = a; cb[i] = b; cop[i] = op; cu[i] = u;
        en[i] = 1;
        g = cyc;
        cycle_();
        en[i] = 0;
        wait_done(i, at);
    endtask

    initial begin
        int g, at0, at1, k;
        bit seen_max;
        logic [W+1:0] e;
        for (int i = 0; i < 2; i++) begin
            cr[i] = 0; ca[i] = '0; cb[i] = '0; cop[i] = '0; cu[i] = 0;
            gap[i] = 0; got[i] = 0; en[i] = 0;
        end
        rnd_ops = 0;
        gmax = 0;
        rst_next = 1;
        repeat (3) cycle_();
        rst_next = 0;

        one_op(0, 32'd5, 32'd3, 3'd0, 1'b0, g, at0);
        chk("t1_latency", 64'(at0 - g), 2);
        chk("t1_result", result, 32'h8);
        chk("t1_owner", result_owner, 0);
        chk("t1_count", ops_count, 1);

        do_reset();
        ca[0] = 32'd10; cb[0] = 32'd4; cop[0] = 3'd1;
        ca[1] = 32'hF0; cb[1] = 32'h0F; cop[1] = 3'd3;
        en[0] = 1; en[1] = 1;
        g = cyc;
        cycle_();
        en[0] = 0; en[1] = 0;
        wait_done(0, at0);
        wait_done(1, at1);
        chk("t2_done0_at", 64'(at0 - g), 2);
        chk("t2_done1_at", 64'(at1 - g), 5);
        chk("t2_result1", result, 32'hFF);

        owners = {};
        en[0] = 1; en[1] = 1;
        k = 0;
        while (owners.size() < 6 && k < 60) begin
            cycle_();
            k++;
        end
        en[0] = 0; en[1] = 0;
        chk("t3_ops", 64'(owners.size()), 6);
        for (int i = 0; i < owners.size() && i < 6; i++) chk("t3_owner_order", owners[i], 64'(i % 2));
        drain();

        one_op(0, 32'h7F00_0000, 32'h0100_0000, 3'd0, 1'b0, g, at0);
        chk("t4_sresult", result, 32'h8000_0000);
        chk("t4_sovf", result_ovf, 1);
        drain();
        one_op(0, 32'h7F00_0000, 32'h0100_0000, 3'd0, 1'b1, g, at0);
        chk("t4_uresult", result, 32'h8000_0000);
        chk("t4_uovf", result_ovf, 0);
        drain();

        ca[1] = 32'h1234; cb[1] = 32'h1111; cop[1] = 3'd4; cu[1] = 1'b1;
        e = alu_fn(ca[1], cb[1], cop[1], cu[1]);
        en[1] = 1;
        cycle_();
        en[1] = 0;
        rst_next = 1;
        cycle_();
        rst_next = 0;
        cycle_();
        chk("t5_no_done", done1, 0);
        chk("t5_result", result, 0);
        chk("t5_count", ops_count, 0);
        chk("t5_busy", busy, 0);
        wait_done(1, at1);
        chk("t5_after_result", result, e[W-1:0]);
        chk("t5_after_owner", result_owner, 1);
        chk("t5_after_count", ops_count, 1);
        drain();

        rnd_ops = 1;
        gmax = 3;
        en[0] = 1; en[1] = 1;
        seen_max = 0;
        k = 0;
        while (k < 4000) begin
            cycle_();
            k++;
            if (seen_max && (got[0] || got[1])) begin
                chk("t6_wrap", ops_count, 0);
                break;
            end
            if (m_cnt == (1 << CW) - 1) seen_max = 1;
        end
        chk("t6_wrap_reached", seen_max, 1);
        for (int i = 0; i < 600; i++) begin
            rst_next = ($urandom_range(99, 0) == 0);
            cycle_();
        end
        rst_next = 0;
        en[0] = 0; en[1] = 0;
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
